fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Elastic instruction buffer between the fetch stage (producer of fetch_out_t) and the decoder (consumer of fetch_out_t).
- Decouples fetch from decode stalls; holds up to DEPTH fetched instructions in program order.
- Supports a pipeline flush on branch mispredict or exception redirect.
- Output entry is passed unchanged to the decoder input.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived; do not override)

Ports:
clk_i  input  1  core clock; all state updates on rising edge
rstn_i  input  1  reset, asynchronous, active-low
flush_i  input  1  synchronous flush; discards all entries
valid_i  input  1  fetch presents a valid instruction
fetch_i  input  fetch_out_t  fetched instruction: pc_inst, inst, bpred
ready_o  output  1  queue can accept an entry this cycle
valid_o  output  1  head entry valid toward decode
decode_o  output  fetch_out_t  head entry, feeds decoder decode_i
ready_i  input  1  decode consumes head this cycle (not stalled)
count_o  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Clock and reset: one clock, clk_i. Reset rstn_i is asynchronous and active-low.
- Reset values:
  - wr_ptr, rd_ptr and count are 0.
  - valid_o is 0, count_o is 0, ready_o is 1.
  - decode_o is all zeros.
  - Storage contents are not reset.
- Push: valid_i && ready_o. Entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: valid_o && ready_i. rd_ptr increments modulo DEPTH.
- count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Output flags:
  - ready_o = (count != DEPTH), combinational from registered count only. ready_o has no dependence on ready_i.
  - valid_o = (count != 0).
  - decode_o = mem[rd_ptr] when valid_o, otherwise all zeros.
- Latency: an entry pushed in cycle N is visible on valid_o and decode_o in cycle N+1. There is no bypass unless the optional feature is enabled.
- Full (count == DEPTH): ready_o is 0 and no push occurs, even if a pop happens that cycle. The freed slot is usable in the next cycle.
- Empty (count == 0): valid_o is 0, and ready_i is ignored.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. count disambiguates the full and empty states.
- Ordering: strict FIFO. Entries are never reordered or duplicated.
- Flush: flush_i has priority over push and pop in the same cycle.
  - Next cycle: pointers and count are 0 and valid_o is 0.
  - An instruction offered on the flush cycle is dropped, even if ready_o was 1.
  - Fetch must re-present post-redirect instructions from the next cycle onward.
- Reset mid-operation: assertion of rstn_i immediately clears outputs to their reset values, independent of the clock.
- Entry fields pc_inst, inst and bpred are stored and forwarded bit-exact with no modification.

Optional Feature:
- Macro: FETCH_DECODE_QUEUE_BYPASS_EN
- Defined:
  - When count == 0, valid_o = valid_i and decode_o = fetch_i combinationally, giving zero latency.
  - If ready_i is also 1 in that cycle, the entry is consumed directly. It is not written, and count stays 0.
  - If ready_i is 0, the entry is written normally.
  - flush_i forces valid_o to 0 in the bypass path.
- Undefined: one-cycle minimum latency, as in Behaviour. There is no combinational path from valid_i or fetch_i to the outputs.

Test Plan:
- Reset: hold rstn_i=0 with random inputs -> valid_o=0, ready_o=1, count_o=0, decode_o=0. Release and push pc 0x1000 -> valid_o=1 on the next cycle with decode_o.pc_inst=0x1000.
- Fill: ready_i=0, push pc 0x0,0x4,0x8,0xC -> count_o=4, ready_o=0. A 5th push of pc 0x10 is not accepted. Then ready_i=1 for 4 cycles -> outputs 0x0,0x4,0x8,0xC in order, then valid_o=0.
- Wrap: stream 10 instructions pc 0x100+4k with ready_i toggling 1,0,1,0 -> all 10 emerge in order with no loss. count_o never exceeds 4.
- Full plus pop: at count=4 assert valid_i=1 and ready_i=1 -> pop occurs, push is rejected, count_o=3. Next cycle the push is accepted and count_o=4.
- Flush: count=3, assert flush_i with valid_i=1 and pc 0x2000 -> next cycle count_o=0, valid_o=0, and 0x2000 is absent. Push pc 0x3000 afterward -> it is the first entry out.
- Bypass (macro defined): empty queue, valid_i=1, ready_i=1, pc 0x40 -> same cycle valid_o=1, decode_o.pc_inst=0x40, and count_o stays 0.

Source files
------------

// File: rtl/fetch_decode_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue_pkg / fetch_decode_queue_if
//
// Purpose : Shared entry type and the handshake bundle for the fetch/decode
//           instruction queue.
//
// fetch_out_t fields:
//   pc_inst : program counter of the fetched instruction
//   inst    : raw instruction word
//   bpred   : branch prediction (taken flag + predicted target)
//
// Interface members (named from the queue's point of view):
//   valid_i  / fetch_i  / ready_o  : fetch-side handshake (fetch -> queue)
//   valid_o  / decode_o / ready_i  : decode-side handshake (queue -> decode)
// Modports:
//   slave  : the queue itself
//   master : the environment (fetch stage + decoder, or a testbench)
// -----------------------------------------------------------------------------
package fetch_decode_queue_pkg;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
   } bpred_t;

   typedef struct packed {
      logic [31:0] pc_inst;
      logic [31:0] inst;
      bpred_t      bpred;
   } fetch_out_t;

endpackage

interface fetch_decode_queue_if;
   import fetch_decode_queue_pkg::*;

   logic       valid_i;
   fetch_out_t fetch_i;
   logic       ready_o;
   logic       valid_o;
   fetch_out_t decode_o;
   logic       ready_i;

   modport slave (
      input  valid_i,
      input  fetch_i,
      input  ready_i,
      output ready_o,
      output valid_o,
      output decode_o
   );

   modport master (
      output valid_i,
      output fetch_i,
      output ready_i,
      input  ready_o,
      input  valid_o,
      input  decode_o
   );

endinterface

// File: rtl/fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue
//
// Purpose : Elastic in-order instruction buffer between fetch and decode.
//           Holds up to DEPTH entries, supports a synchronous flush that has
//           priority over push and pop. Entries pass through bit-exact.
//
// Ports:
//   clk_i    : core clock, all state changes on the rising edge
//   rstn_i   : asynchronous active-low reset
//   flush_i  : synchronous flush, discards every entry (and any offer)
//   q_if     : fetch_decode_queue_if.slave (fetch and decode handshakes)
//   count_o  : current occupancy, 0..DEPTH
//
// Optional feature: define FETCH_DECODE_QUEUE_BYPASS_EN to let an entry pass
// straight from fetch_i to decode_o while the queue is empty (zero latency).
// Without it there is no combinational path from the fetch side to outputs.
// -----------------------------------------------------------------------------
module fetch_decode_queue
   import fetch_decode_queue_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               flush_i,
   fetch_decode_queue_if.slave q_if,
   output logic [CNT_W-1:0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   // Storage is intentionally not reset; count gates everything visible.
   fetch_out_t       mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic             empty;
   logic             full;
   logic             push;
   logic             pop;

   // Handshake flags and head output. ready_o depends only on the registered
   // count, so an async reset immediately restores the reset-state outputs.
   always_comb begin
      empty        = (count_q == '0);
      full         = (count_q == CNT_W'(DEPTH));
      q_if.ready_o = !full;
      pop          = !empty && q_if.ready_i;
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
      // While empty, the offered entry is shown directly. If decode takes it
      // in the same cycle it is never written; otherwise it is stored as usual.
      q_if.valid_o  = !empty || (q_if.valid_i && !flush_i);
      if (!empty) begin
         q_if.decode_o = mem[rd_ptr_q];
      end else if (q_if.valid_i && !flush_i) begin
         q_if.decode_o = q_if.fetch_i;
      end else begin
         q_if.decode_o = '0;
      end
      push = q_if.valid_i && !full && !(empty && q_if.ready_i);
`else
      q_if.valid_o  = !empty;
      q_if.decode_o = empty ? fetch_out_t'('0) : mem[rd_ptr_q];
      push          = q_if.valid_i && !full;
`endif
   end

   // Next-state: flush wins over everything; a full queue never accepts a
   // push even when a pop frees a slot in the same cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !flush_i) begin
         mem[wr_ptr_q] <= q_if.fetch_i;
      end
   end

   assign count_o = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;
   import fetch_decode_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk_i = 1'b0;
   logic             rstn_i;
   logic             flush_i;
   logic [CNT_W-1:0] count_o;

   fetch_decode_queue_if q_if ();

   fetch_decode_queue #(.DEPTH(DEPTH)) dut (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .flush_i (flush_i),
      .q_if    (q_if.slave),
      .count_o (count_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: the queue contents in program order.
   fetch_out_t model_q[$];
   int         n_cmp = 0;
   int         n_err = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic fetch_out_t mk(input logic [31:0] pc);
      fetch_out_t e;
      e.pc_inst      = pc;
      e.inst         = $urandom;
      e.bpred.taken  = 1'($urandom_range(0, 1));
      e.bpred.target = $urandom;
      return e;
   endfunction

   // Expected outputs from the model contents and the inputs currently driven.
   task automatic check_outputs();
      logic       exp_valid;
      fetch_out_t exp_data;
      exp_valid = 1'b0;
      exp_data  = '0;
      if (model_q.size() != 0) begin
         exp_valid = 1'b1;
         exp_data  = model_q[0];
      end
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
      else if (q_if.valid_i && !flush_i) begin
         exp_valid = 1'b1;
         exp_data  = q_if.fetch_i;
      end
`endif
      chk("count_o",  128'(count_o),       128'(model_q.size()));
      chk("ready_o",  128'(q_if.ready_o),  128'(model_q.size() != DEPTH));
      chk("valid_o",  128'(q_if.valid_o),  128'(exp_valid));
      chk("decode_o", 128'(q_if.decode_o), 128'(exp_data));
   endtask

   // One clock cycle: drive, check, then advance the model across the edge.
   task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                       input logic fl, output logic acc);
      fetch_out_t fin;
      bit         byp;
      bit         do_push;
      @(negedge clk_i);
      fin          = mk(pc);
      q_if.valid_i = v;
      q_if.fetch_i = fin;
      q_if.ready_i = rdy;
      flush_i      = fl;
      #1;
      check_outputs();
      acc = v && !fl && (model_q.size() != DEPTH);
      byp = 1'b0;
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
      byp = (model_q.size() == 0) && v && rdy && !fl;
`endif
      @(posedge clk_i);
      if (fl) begin
         model_q.delete();
      end else if (byp) begin
         $display("pop  pc=%08h (bypass)", fin.pc_inst);
      end else begin
         do_push = v && (model_q.size() != DEPTH);
         if (model_q.size() != 0 && rdy) begin
            $display("pop  pc=%08h", model_q[0].pc_inst);
            void'(model_q.pop_front());
         end
         if (do_push) model_q.push_back(fin);
      end
   endtask

   task automatic drain();
      logic acc;
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
   endtask

   initial begin
      logic acc;
      int   k;
      int   t;

      // Reset held with random inputs.
      rstn_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         q_if.valid_i = 1'($urandom_range(0, 1));
         q_if.fetch_i = mk($urandom);
         q_if.ready_i = 1'($urandom_range(0, 1));
         flush_i      = 1'($urandom_range(0, 1));
         #1;
         chk("rst_valid",  128'(q_if.valid_o),  128'(0));
         chk("rst_ready",  128'(q_if.ready_o),  128'(1));
         chk("rst_count",  128'(count_o),       128'(0));
         chk("rst_decode", 128'(q_if.decode_o), 128'(0));
      end
      @(negedge clk_i);
      q_if.valid_i = 1'b0;
      q_if.ready_i = 1'b0;
      flush_i      = 1'b0;
      rstn_i       = 1'b1;

      step(1'b1, 32'h1000, 1'b0, 1'b0, acc);
      step(1'b0, 32'h0,    1'b1, 1'b0, acc);
      chk("first_pc", 128'(q_if.decode_o.pc_inst), 128'(32'h1000));

      // Fill, reject the fifth, then drain in order.
      for (int i = 0; i < 5; i++) step(1'b1, 32'(4 * i), 1'b0, 1'b0, acc);
      chk("fill_count", 128'(count_o), 128'(4));
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0, acc);
         chk("fill_order", 128'(q_if.decode_o.pc_inst), 128'(32'(4 * i)));
      end
      step(1'b0, 32'h0, 1'b1, 1'b0, acc);

      // Wrap: 10 instructions, ready toggling, re-presented until taken.
      k = 0;
      t = 0;
      while (k < 10 && t < 200) begin
         step(1'b1, 32'h100 + 32'(4 * k), (t % 2) == 0, 1'b0, acc);
         if (acc) k++;
         t++;
      end
      drain();

      // Full plus pop: push rejected, accepted the next cycle.
      for (int i = 0; i < 4; i++) step(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0, acc);
      step(1'b1, 32'h500, 1'b1, 1'b0, acc);
      step(1'b1, 32'h500, 1'b0, 1'b0, acc);
      step(1'b0, 32'h0,   1'b0, 1'b0, acc);
      chk("fullpop_count", 128'(count_o), 128'(4));
      drain();

      // Flush with an offer on the same cycle.
      for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0, acc);
      step(1'b1, 32'h2000, 1'b0, 1'b1, acc);
      step(1'b1, 32'h3000, 1'b0, 1'b0, acc);
      step(1'b0, 32'h0,    1'b1, 1'b0, acc);
      chk("flush_head", 128'(q_if.decode_o.pc_inst), 128'(32'h3000));
      step(1'b0, 32'h0, 1'b1, 1'b0, acc);

      // Bypass case (outcome depends on the build; the model follows it).
      step(1'b1, 32'h40, 1'b1, 1'b0, acc);

      // Asynchronous reset in the middle of a cycle.
      for (int i = 0; i < 3; i++) step(1'b1, 32'h700 + 32'(4 * i), 1'b0, 1'b0, acc);
      @(negedge clk_i);
      q_if.valid_i = 1'b0;
      q_if.ready_i = 1'b0;
      #2 rstn_i = 1'b0;
      #1;
      chk("arst_valid",  128'(q_if.valid_o),  128'(0));
      chk("arst_ready",  128'(q_if.ready_o),  128'(1));
      chk("arst_count",  128'(count_o),       128'(0));
      chk("arst_decode", 128'(q_if.decode_o), 128'(0));
      model_q.delete();
      @(negedge clk_i);
      rstn_i = 1'b1;

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), {$urandom_range(0, 65535), 2'b00},
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), acc);
      end
      step(1'b0, 32'h0, 1'b0, 1'b0, acc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
